// File: rtl/csa_32.sv
// -----------------------------------------------------------------------------
// csa_32 : 32-bit carry-select adder with registered result.
//
// Computes {cout, sum} = a + b + cin as a 33-bit unsigned sum and registers
// it on the rising clock edge (latency 1, one new operation per cycle).
//
// Adder structure: block 0 (bits 3:0) is a plain 4-bit ripple adder fed by
// cin. Blocks 1..7 each compute two 4-bit ripple results in parallel, one
// assuming carry-in 0 and one assuming carry-in 1. The carry selected by the
// previous block picks the correct result. The carry selected by block 7
// becomes cout.
//
// Ports:
//   clock    in   1   system clock, rising-edge active
//   reset_n  in   1   asynchronous active-low reset, clears sum/cout
//   a        in   32  addend A, unsigned
//   b        in   32  addend B, unsigned
//   cin      in   1   carry in, bit-0 weight
//   cout     out  1   registered carry out of bit 31
//   sum      out  32  registered sum bits [31:0]
// -----------------------------------------------------------------------------
module csa_32 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic        cout,
  output logic [31:0] sum
);

  // Single-bit full adder; returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    logic s;
    logic co;
    s  = x ^ y ^ c;
    co = (x & y) | (c & (x ^ y));
    return {co, s};
  endfunction

  // 4-bit ripple adder; returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] ripple4(input logic [3:0] x, input logic [3:0] y,
                                         input logic c);
    logic [3:0] s;
    logic       cc;
    logic [1:0] fa;
    cc = c;
    s  = 4'h0;
    for (int i = 0; i < 4; i++) begin
      fa   = full_add(x[i], y[i], cc);
      s[i] = fa[0];
      cc   = fa[1];
    end
    return {cc, s};
  endfunction

  logic [31:0] sum_comb;
  logic        cout_comb;
  logic        carry;
  logic [4:0]  blk0;
  logic [4:0]  res_c0;
  logic [4:0]  res_c1;

  // Combinational carry-select core: ripple block 0, then select per block.
  always_comb begin
    sum_comb  = 32'h0;
    cout_comb = 1'b0;
    res_c0    = 5'h00;
    res_c1    = 5'h00;
    blk0      = ripple4(a[3:0], b[3:0], cin);
    sum_comb[3:0] = blk0[3:0];
    carry     = blk0[4];
    for (int k = 1; k < 8; k++) begin
      // Both candidate results are independent of the incoming carry, so
      // only the 2:1 select sits on the block-to-block carry path.
      res_c0 = ripple4(a[4*k +: 4], b[4*k +: 4], 1'b0);
      res_c1 = ripple4(a[4*k +: 4], b[4*k +: 4], 1'b1);
      if (carry) begin
        sum_comb[4*k +: 4] = res_c1[3:0];
        carry              = res_c1[4];
      end else begin
        sum_comb[4*k +: 4] = res_c0[3:0];
        carry              = res_c0[4];
      end
    end
    cout_comb = carry;
  end

  // Result register; reset clears the result and discards any pending sum.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum  <= 32'h0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_comb;
      cout <= cout_comb;
    end
  end

endmodule

// File: tb/tb_csa_32.sv
// -----------------------------------------------------------------------------
// tb_csa_32 : scoreboard bench for csa_32.
// The driver applies operands on the falling edge and pushes the expected
// {cout, sum} into a queue; a separate monitor pops and compares 1 time unit
// after each rising edge whenever a result is pending.
// -----------------------------------------------------------------------------
module tb_csa_32;

  logic        clock;
  logic        reset_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        cout;
  logic [31:0] sum;

  logic [32:0] exp_q[$];
  int          n_checks;
  int          n_pass;
  bit          done;

  csa_32 dut (
    .clock   (clock),
    .reset_n (reset_n),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .cout    (cout),
    .sum     (sum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h (time %0t)", name, act, req, $time);
    end
  endtask

  // Drive one operation at the falling edge and record its expected result.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                       input logic [32:0] expv);
    @(negedge clock);
    a   = av;
    b   = bv;
    cin = cv;
    exp_q.push_back(expv);
  endtask

  function automatic logic [32:0] ref_add(input logic [31:0] av, input logic [31:0] bv,
                                          input logic cv);
    return {1'b0, av} + {1'b0, bv} + {32'h0, cv};
  endfunction

  // Pulse reset in the middle of a cycle with an operation pending.
  task automatic reset_pulse(input string name);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check({name, "_async"}, {cout, sum}, 33'h0);
    @(posedge clock);
    #1;
    check({name, "_hold"}, {cout, sum}, 33'h0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Monitor: compare the pending expectation after every rising edge.
  initial begin
    logic [32:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result", {cout, sum}, e);
      end
    end
  end

  initial begin
    logic [31:0] ca;
    logic [31:0] cb;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    n_checks = 0;
    n_pass   = 0;
    done     = 1'b0;
    reset_n  = 1'b1;
    a        = 32'hFFFF_FFFF;
    b        = 32'hFFFF_FFFF;
    cin      = 1'b1;

    // Reset clears the outputs without any clock edge.
    #1;
    reset_n = 1'b0;
    #1;
    check("reset_no_edge", {cout, sum}, 33'h0);
    @(posedge clock);
    #1;
    check("reset_hold", {cout, sum}, 33'h0);

    // Release: first result reflects the inputs at the first rising edge.
    @(negedge clock);
    reset_n = 1'b1;
    a   = 32'hFFFF_FFFF;
    b   = 32'hFFFF_FFFF;
    cin = 1'b0;
    exp_q.push_back(33'h1_FFFF_FFFE);
    #1;
    check("release_before_edge", {cout, sum}, 33'h0);

    // Directed vectors with hand-computed results.
    issue(32'h0000_0001, 32'h0000_0001, 1'b1, 33'h0_0000_0003);
    issue(32'h0000_0002, 32'h0000_0001, 1'b0, 33'h0_0000_0003);
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
    issue(32'h0000_000F, 32'h0000_0001, 1'b0, 33'h0_0000_0010);
    issue(32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_1000_0000);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000);
    issue(32'h1234_5678, 32'h8765_4321, 1'b0, 33'h0_9999_9999);
    issue(32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 33'h1_0000_0000);
    issue(32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000);
    issue(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 33'h0_8000_0000);

    // Inputs changing between edges must not disturb the registered result.
    @(negedge clock);
    a   = 32'hDEAD_BEEF;
    b   = 32'h0000_0000;
    cin = 1'b0;
    exp_q.push_back(33'h0_DEAD_BEEF);
    @(posedge clock);
    #2;
    a = 32'h1111_1111;
    #1;
    check("mid_cycle_stable", {cout, sum}, 33'h0_DEAD_BEEF);

    // Reset during a pending operation discards it.
    issue(32'h0000_0005, 32'h0000_0006, 1'b0, 33'h0_0000_000B);
    reset_pulse("reset_pending");
    a   = 32'h0000_0001;
    b   = 32'h0000_0002;
    cin = 1'b0;
    exp_q.push_back(33'h0_0000_0003);

    // Incrementing sweep with toggling carry-in.
    ca = 32'hFFFF_F000;
    cb = 32'h0000_0F00;
    for (int i = 0; i < 1200; i++) begin
      issue(ca, cb, i[0], ref_add(ca, cb, i[0]));
      ca = ca + 32'h0000_0003;
      cb = cb + 32'h0101_0101;
    end

    // Random operands with occasional mid-run reset pulses.
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1, 0));
      if ((i % 8) == 3) rb = ~ra;
      issue(ra, rb, rc, ref_add(ra, rb, rc));
      if ((i % 2000) == 1999) begin
        reset_pulse("reset_random");
        a   = ra;
        b   = rb;
        cin = rc;
        exp_q.push_back(ref_add(ra, rb, rc));
      end
    end

    @(posedge clock);
    #3;
    check("queue_drained", 33'(exp_q.size()), 33'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
